// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Accepts decoded RV32I instruction fields over a valid/ready
//               stream, packs each tuple into a 32-bit instruction word and
//               writes the words to consecutive instruction-memory locations.
//               Used to fill imem before the core leaves reset.
// Ports       : clk, reset (async, active-high)
//               start                      - begin a load session
//               in_valid/in_ready          - field tuple handshake
//               in_type/opcode/rd/rs1/rs2/funct3/funct7/imm/last - tuple
//               imem_we/imem_addr/imem_wdata - memory write port
//               busy/done/full/err/count   - session status
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int          ADDR_WIDTH = 6,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_type,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [31:0]           in_imm,
    input  logic                  in_last,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  full,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_write = 3'd2;
    localparam logic [2:0] c_st_done  = 3'd3;
    localparam logic [2:0] c_st_error = 3'd4;

    localparam logic [ADDR_WIDTH:0] c_one   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [2:0]          r_state;
    logic [ADDR_WIDTH:0] r_count;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_last;
    logic                r_full;
    logic                r_err;

    logic [31:0]         w_enc;
    logic                w_legal;
    logic                w_accept;
    logic [ADDR_WIDTH:0] w_count_next;

    // Field packing per instruction format.
    always_comb begin
        w_enc = 32'h0;
        case (in_type)
            3'd0: w_enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            3'd2: w_enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            3'd3: w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
            3'd4: w_enc = {in_imm[31:12], in_rd, in_opcode};
            3'd5: w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, in_opcode};
            default: w_enc = 32'h0;
        endcase
    end

    // Branch/jump offsets are halfword multiples, so an odd offset cannot be encoded.
    always_comb begin
        w_legal = (in_type <= 3'd5) && (in_opcode[1:0] == 2'b11);
        if (((in_type == 3'd3) || (in_type == 3'd5)) && in_imm[0]) begin
            w_legal = 1'b0;
        end
    end

    assign w_accept     = in_valid && (r_state == c_st_load);
    assign w_count_next = r_count + c_one;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_count <= '0;
            r_addr  <= BASE_ADDR;
            r_wdata <= 32'h0;
            r_last  <= 1'b0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done, c_st_error: begin
                    if (start) begin
                        r_state <= c_st_load;
                        r_count <= '0;
                        r_addr  <= BASE_ADDR;
                        r_full  <= 1'b0;
                        r_err   <= 1'b0;
                    end else if (r_state == c_st_done) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_load: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_wdata <= w_enc;
                            r_last  <= in_last;
                            r_state <= c_st_write;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= c_st_error;
                        end
                    end
                end
                c_st_write: begin
                    // The write strobe is combinational on this state; here we
                    // advance past the word that was just written.
                    r_count <= w_count_next;
                    r_addr  <= r_addr + 32'd4;
                    if (r_last || (w_count_next == c_depth)) begin
                        r_full  <= ~r_last;
                        r_state <= c_st_done;
                    end else begin
                        r_state <= c_st_load;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign in_ready   = (r_state == c_st_load);
    assign imem_we    = (r_state == c_st_write);
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign busy       = (r_state == c_st_load) || (r_state == c_st_write);
    assign done       = (r_state == c_st_done);
    assign full       = r_full;
    assign err        = r_err;
    assign count      = r_count;

endmodule
`default_nettype wire
